// File: rtl/bcd_countdown_timer_pkg.sv
// Shared types and helpers for the BCD countdown timer.
// Pair validity check used for preset validation.
package timer_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSED,
        EXPIRED
    } state_t;

    localparam bcd_t BCD_ONES_MAX = 4'd9;
    localparam bcd_t BCD_TENS_MAX = 4'd5;

    function automatic logic bcd_pair_valid(
        input logic [7:0] pair,
        input bcd_t       tens_max
    );
        return (pair[3:0] <= BCD_ONES_MAX) && (pair[7:4] <= tens_max);
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_if.sv
// Control/status bundle of the BCD countdown timer.
// master drives load/preset/start/pause, slave is the timer.
interface bcd_countdown_timer_if #(
    parameter int NUM_PAIRS = 3
);

    logic                   load;
    logic [8*NUM_PAIRS-1:0] preset;
    logic                   start;
    logic                   pause;
    logic [8*NUM_PAIRS-1:0] digits;
    logic                   running;
    logic                   expired;
    logic                   done;
    logic                   load_err;

    modport master (
        output load, preset, start, pause,
        input  digits, running, expired, done, load_err
    );

    modport slave (
        input  load, preset, start, pause,
        output digits, running, expired, done, load_err
    );

endinterface

// File: rtl/bcd_countdown_timer_pair_down.sv
// One two-digit BCD down-counter field (00..TENS_MAX9).
// borrow_out requests a decrement of the next field when wrapping from 00.
module bcd_pair_down
    import timer_pkg::*;
#(
    parameter bcd_t TENS_MAX = BCD_TENS_MAX
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dec,
    input  logic       load,
    input  logic [7:0] ld_val,
    output logic [7:0] val,
    output logic       zero,
    output logic       borrow_out
);

    bcd_t ones;
    bcd_t tens;

    always_ff @(posedge clk) begin
        if (rst) begin
            ones <= '0;
            tens <= '0;
        end else if (load) begin
            ones <= ld_val[3:0];
            tens <= ld_val[7:4];
        end else if (dec) begin
            if (ones == 4'd0) begin
                ones <= BCD_ONES_MAX;
                tens <= (tens == 4'd0) ? TENS_MAX : tens - 4'd1;
            end else begin
                ones <= ones - 4'd1;
            end
        end
    end

    assign val        = {tens, ones};
    assign zero       = (ones == 4'd0) && (tens == 4'd0);
    assign borrow_out = dec && zero;

endmodule

// File: rtl/bcd_countdown_timer.sv
// BCD countdown timer: FSM, tick prescaler, preset validation, pair chain.
// AUTO_RELOAD_EN: reload the last accepted preset on expiry instead of stopping.
module bcd_countdown_timer
    import timer_pkg::*;
#(
    parameter int NUM_PAIRS = 3,
    parameter int TICK_DIV  = 1,
    parameter int TOP_TENS  = 9
) (
    input logic                 clk,
    input logic                 rst,
    bcd_countdown_timer_if.slave bus
);

    localparam int W  = 8 * NUM_PAIRS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    state_t          state;
    logic [PW-1:0]   presc;
    logic [W-1:0]    count;
    logic [W-1:0]    ld_val;
    logic [NUM_PAIRS-1:0] zeros;
    logic [NUM_PAIRS-1:0] borrow;
    logic [NUM_PAIRS-1:0] dec;
    logic            preset_ok;
    logic            ld_ok;
    logic            count_zero;
    logic            count_one;
    logic            presc_end;
    logic            tick;
    logic            reload;
    logic            pair_load;
    logic            running_q;
    logic            expired_q;
    logic            done_q;
    logic            load_err_q;
    logic            unused_borrow;

    always_comb begin
        preset_ok = 1'b1;
        for (int k = 0; k < NUM_PAIRS; k++) begin
            if (!bcd_pair_valid(bus.preset[8*k +: 8],
                    (k == NUM_PAIRS - 1) ? bcd_t'(TOP_TENS) : BCD_TENS_MAX))
                preset_ok = 1'b0;
        end
    end

    assign ld_ok      = bus.load && preset_ok;
    assign count_zero = &zeros;
    assign count_one  = (count == W'(1));
    assign presc_end  = (presc == PW'(TICK_DIV - 1));
    assign tick       = (state == RUN) && !bus.load && !bus.pause && presc_end;

`ifdef AUTO_RELOAD_EN
    logic [W-1:0] shadow;

    always_ff @(posedge clk) begin
        if (rst)
            shadow <= '0;
        else if (ld_ok)
            shadow <= bus.preset;
    end

    // Zero shadow means nothing to reload: fall through to a normal expiry.
    assign reload = (shadow != '0);
    assign ld_val = ld_ok ? bus.preset : shadow;
`else
    assign reload = 1'b0;
    assign ld_val = bus.preset;
`endif

    assign pair_load = ld_ok || (tick && count_one && reload);

    genvar k;
    generate
        for (k = 0; k < NUM_PAIRS; k++) begin : g_pair
            localparam bcd_t TM = (k == NUM_PAIRS - 1) ?
                bcd_t'(TOP_TENS) : BCD_TENS_MAX;

            if (k == 0) begin : g_first
                assign dec[k] = tick && !count_zero && !(count_one && reload);
            end else begin : g_next
                assign dec[k] = borrow[k-1];
            end

            bcd_pair_down #(
                .TENS_MAX (TM)
            ) u_pair (
                .clk        (clk),
                .rst        (rst),
                .dec        (dec[k]),
                .load       (pair_load),
                .ld_val     (ld_val[8*k +: 8]),
                .val        (count[8*k +: 8]),
                .zero       (zeros[k]),
                .borrow_out (borrow[k])
            );
        end
    endgenerate

    assign unused_borrow = borrow[NUM_PAIRS-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            presc      <= '0;
            running_q  <= 1'b0;
            expired_q  <= 1'b0;
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            done_q     <= 1'b0;
            load_err_q <= 1'b0;
            if (bus.load) begin
                if (preset_ok) begin
                    state     <= IDLE;
                    presc     <= '0;
                    running_q <= 1'b0;
                    expired_q <= 1'b0;
                end else begin
                    load_err_q <= 1'b1;
                end
            end else if (bus.pause) begin
                if (state == RUN) begin
                    state     <= PAUSED;
                    running_q <= 1'b0;
                end
            end else if (state == RUN) begin
                if (presc_end) begin
                    presc <= '0;
                    if (count_one) begin
                        done_q <= 1'b1;
                        if (!reload) begin
                            state     <= EXPIRED;
                            running_q <= 1'b0;
                            expired_q <= 1'b1;
                        end
                    end
                end else begin
                    presc <= presc + PW'(1);
                end
            end else if (bus.start && !count_zero &&
                         (state == IDLE || state == PAUSED)) begin
                state     <= RUN;
                running_q <= 1'b1;
            end
        end
    end

    assign bus.digits   = count;
    assign bus.running  = running_q;
    assign bus.expired  = expired_q;
    assign bus.done     = done_q;
    assign bus.load_err = load_err_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Randomized self-checking bench for bcd_countdown_timer against an
// integer-count reference model (honours AUTO_RELOAD_EN when defined).
module tb_bcd_countdown_timer;

    localparam int NP = 3;
    localparam int TD = 3;
    localparam int TT = 9;
    localparam int W  = 8 * NP;

    localparam int S_IDLE = 0;
    localparam int S_RUN  = 1;
    localparam int S_PAUS = 2;
    localparam int S_EXP  = 3;

    logic clk = 1'b0;
    logic rst;

    bcd_countdown_timer_if #(.NUM_PAIRS(NP)) bus ();

    bcd_countdown_timer #(
        .NUM_PAIRS (NP),
        .TICK_DIV  (TD),
        .TOP_TENS  (TT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    int n_err = 0;
    int n_chk = 0;

    int m_val   = 0;
    int m_st    = S_IDLE;
    int m_presc = 0;
    int m_shad  = 0;
    bit m_done  = 0;
    bit m_lerr  = 0;

    function automatic int radix(int k);
        return (k == NP - 1) ? (TT + 1) * 10 : 60;
    endfunction

    function automatic logic [W-1:0] to_bcd(int v);
        logic [W-1:0] b = '0;
        for (int k = 0; k < NP; k++) begin
            int r = radix(k);
            int p = v % r;
            v = v / r;
            b[8*k +: 8] = {4'(p / 10), 4'(p % 10)};
        end
        return b;
    endfunction

    function automatic int to_int(logic [W-1:0] b);
        int v = 0;
        for (int k = NP - 1; k >= 0; k--)
            v = v * radix(k) + int'(b[8*k+4 +: 4]) * 10 + int'(b[8*k +: 4]);
        return v;
    endfunction

    function automatic bit valid(logic [W-1:0] b);
        for (int k = 0; k < NP; k++) begin
            if (b[8*k +: 4] > 4'd9) return 1'b0;
            if (int'(b[8*k+4 +: 4]) > ((k == NP - 1) ? TT : 5)) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model(input bit r, input bit ld, input logic [W-1:0] p,
                         input bit st, input bit ps);
        m_done = 0;
        m_lerr = 0;
        if (r) begin
            m_val = 0; m_st = S_IDLE; m_presc = 0; m_shad = 0;
        end else if (ld) begin
            if (valid(p)) begin
                m_val = to_int(p); m_st = S_IDLE; m_presc = 0; m_shad = m_val;
            end else begin
                m_lerr = 1;
            end
        end else if (ps) begin
            if (m_st == S_RUN) m_st = S_PAUS;
        end else if (m_st == S_RUN) begin
            if (m_presc == TD - 1) begin
                m_presc = 0;
                m_val--;
                if (m_val == 0) begin
                    m_done = 1;
`ifdef AUTO_RELOAD_EN
                    if (m_shad != 0) m_val = m_shad;
                    else m_st = S_EXP;
`else
                    m_st = S_EXP;
`endif
                end
            end else begin
                m_presc++;
            end
        end else if (st && m_val != 0 && (m_st == S_IDLE || m_st == S_PAUS)) begin
            m_st = S_RUN;
        end
    endtask

    task automatic step(input bit r, input bit ld, input logic [W-1:0] p,
                        input bit st, input bit ps);
        rst        = r;
        bus.load   = ld;
        bus.preset = p;
        bus.start  = st;
        bus.pause  = ps;
        model(r, ld, p, st, ps);
        @(posedge clk);
        #1;
        check("digits",   32'(bus.digits),   32'(to_bcd(m_val)));
        check("running",  32'(bus.running),  32'(m_st == S_RUN));
        check("expired",  32'(bus.expired),  32'(m_st == S_EXP));
        check("done",     32'(bus.done),     32'(m_done));
        check("load_err", 32'(bus.load_err), 32'(m_lerr));
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, '0, 0, 0);
    endtask

    initial begin
        int nd;
        logic [W-1:0] p;

        rst = 1'b1;
        bus.load = 0; bus.preset = '0; bus.start = 0; bus.pause = 0;
        step(1, 0, '0, 0, 0);
        check("rst_digits", 32'(bus.digits), 32'h0);
        check("rst_running", 32'(bus.running), 32'h0);

        // reset in the middle of a run
        step(0, 1, 24'h000500, 0, 0);
        step(0, 0, '0, 1, 0);
        idle(7);
        step(1, 0, '0, 0, 0);
        check("rst_mid_run", 32'(bus.digits), 32'h0);

        // one minute down to zero
        step(0, 1, 24'h000100, 0, 0);
        step(0, 0, '0, 1, 0);
        idle(TD);
        check("first_tick", 32'(bus.digits), 32'h000059);
        nd = 0;
        for (int i = 0; i < 60 * TD + 5; i++) begin
            step(0, 0, '0, 0, 0);
            if (bus.done) nd++;
        end
`ifndef AUTO_RELOAD_EN
        check("done_once", 32'(nd), 32'd1);
        step(0, 0, '0, 1, 0);
        check("start_ignored_exp", 32'(bus.expired), 32'h1);
`endif

        // full borrow chain
        step(0, 1, 24'h100000, 0, 0);
        step(0, 0, '0, 1, 0);
        idle(TD);
        check("borrow_chain", 32'(bus.digits), 32'h095959);

        // pause / hold / resume
        step(0, 1, 24'h000003, 0, 0);
        step(0, 0, '0, 1, 0);
        idle(5);
        step(0, 0, '0, 0, 1);
        idle(10);
        step(0, 0, '0, 1, 1);
        check("pause_wins", 32'(bus.running), 32'h0);
        step(0, 0, '0, 1, 0);
        idle(3 * TD + 2);

        // invalid preset, then zero preset with start
        step(0, 1, 24'h000700, 0, 0);
        step(0, 1, 24'h007A00, 0, 0);
        check("bad_load_err", 32'(bus.load_err), 32'h1);
        check("bad_load_keep", 32'(bus.digits), 32'h000700);
        step(0, 1, 24'h000000, 0, 0);
        step(0, 0, '0, 1, 0);
        check("zero_start", 32'(bus.running), 32'h0);
        idle(4);

        // load + start together: load wins
        step(0, 1, 24'h000002, 1, 0);
        check("load_over_start", 32'(bus.running), 32'h0);
        step(0, 0, '0, 1, 0);
        idle(6 * TD + 2);

        for (int i = 0; i < 4000; i++) begin
            case ($urandom % 4)
                0:       p = W'($urandom);
                1:       p = to_bcd(int'($urandom_range(0, 359999)));
                default: p = to_bcd(int'($urandom_range(0, 12)));
            endcase
            step(($urandom % 400) == 0, ($urandom % 24) == 0, p,
                 ($urandom % 5) == 0, ($urandom % 20) == 0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
